// File: rtl/clock_time_counter.sv
// clock_time_counter
//   Timekeeping core: divides clk down to a 1 Hz tick and keeps
//   hours/minutes/seconds as binary counters. Every output is registered.
//   Set pulses adjust minutes and hours.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   run       1 = prescaler advances, 0 = time frozen
//   clr       synchronous clear of time and prescaler
//   inc_min   minute +1 per high cycle (no carry into hour)
//   inc_hour  hour +1 per high cycle
//   sec       seconds 0..59 (binary)
//   min       minutes 0..59 (binary)
//   hour      hours 0..23 (binary)
//   tick_1hz  one-cycle pulse, high when the new sec value is visible
//   day_wrap  one-cycle pulse, high when 23:59:59 rolls to 00:00:00
module clock_time_counter #(
  parameter int unsigned CLK_DIV = 100000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       clr,
  input  logic       inc_min,
  input  logic       inc_hour,
  output logic [7:0] sec,
  output logic [7:0] min,
  output logic [7:0] hour,
  output logic       tick_1hz,
  output logic       day_wrap
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       sec_q, sec_d;
  logic [7:0]       min_q, min_d;
  logic [7:0]       hour_q, hour_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;

  logic tick;
  logic sec_carry;
  logic min_carry;

  always_comb begin
    tick      = run && (div_q == DIV_LAST);
    sec_carry = tick && (sec_q == 8'd59);
    // Only the tick-driven cascade carries into hour; inc_min never does.
    min_carry = sec_carry && (min_q == 8'd59);

    div_d  = div_q;
    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;

    if (clr) begin
      div_d  = '0;
      sec_d  = '0;
      min_d  = '0;
      hour_d = '0;
    end else begin
      if (run) begin
        div_d = tick ? '0 : div_q + 1'b1;
      end

      if (tick) begin
        sec_d  = sec_carry ? 8'd0 : sec_q + 8'd1;
        tick_d = 1'b1;
      end

      // A carry and a set pulse in the same cycle still advance by one.
      if (sec_carry || inc_min) begin
        min_d = (min_q == 8'd59) ? 8'd0 : min_q + 8'd1;
      end

      if (min_carry || inc_hour) begin
        hour_d = (hour_q == 8'd23) ? 8'd0 : hour_q + 8'd1;
      end

      wrap_d = min_carry && (hour_q == 8'd23);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      sec_q  <= '0;
      min_q  <= '0;
      hour_q <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      sec_q  <= sec_d;
      min_q  <= min_d;
      hour_q <= hour_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end

  assign sec      = sec_q;
  assign min      = min_q;
  assign hour     = hour_q;
  assign tick_1hz = tick_q;
  assign day_wrap = wrap_q;

endmodule

// File: tb/tb_clock_time_counter.sv
module tb_clock_time_counter;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       clr;
  logic       inc_min;
  logic       inc_hour;
  logic [7:0] sec;
  logic [7:0] min;
  logic [7:0] hour;
  logic       tick_1hz;
  logic       day_wrap;

  int tests_run;
  int tests_failed;

  clock_time_counter #(.CLK_DIV(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .clr      (clr),
    .inc_min  (inc_min),
    .inc_hour (inc_hour),
    .sec      (sec),
    .min      (min),
    .hour     (hour),
    .tick_1hz (tick_1hz),
    .day_wrap (day_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    check({tag, ".hour"}, hour, 8'(h));
    check({tag, ".min"}, min, 8'(m));
    check({tag, ".sec"}, sec, 8'(s));
  endtask

  // Clear, load m/h with held set pulses (frozen), then run s ticks.
  // Leaves the prescaler at 0 and run low.
  task automatic goto(input int h, input int m, input int s);
    run = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 60; i++) begin
      inc_min  = (i < m);
      inc_hour = (i < h);
      step();
    end
    inc_min  = 1'b0;
    inc_hour = 1'b0;
    run = 1'b1;
    repeat (4 * s) step();
    run = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n    = 1'b0;
    run      = 1'b0;
    clr      = 1'b0;
    inc_min  = 1'b0;
    inc_hour = 1'b0;

    // 1. reset state, then count with ticks every 4 cycles
    step();
    check_time("reset", 0, 0, 0);
    check("reset.tick", {7'd0, tick_1hz}, 8'd0);
    check("reset.wrap", {7'd0, day_wrap}, 8'd0);
    rst_n = 1'b1;
    run   = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      check($sformatf("count.tick%0d", k), {7'd0, tick_1hz}, (k % 4 == 0) ? 8'd1 : 8'd0);
    end
    check_time("count", 0, 0, 4);

    // 2. cascade 12:59:58 -> 12:59:59 -> 13:00:00
    goto(12, 59, 58);
    check_time("preload", 12, 59, 58);
    run = 1'b1;
    repeat (4) step();
    check_time("casc1", 12, 59, 59);
    check("casc1.tick", {7'd0, tick_1hz}, 8'd1);
    repeat (4) step();
    check_time("casc2", 13, 0, 0);
    check("casc2.tick", {7'd0, tick_1hz}, 8'd1);
    check("casc2.wrap", {7'd0, day_wrap}, 8'd0);

    // 3. day wrap
    goto(23, 59, 59);
    run = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      check("dw.pre_wrap", {7'd0, day_wrap}, 8'd0);
    end
    step();
    check_time("dw", 0, 0, 0);
    check("dw.wrap", {7'd0, day_wrap}, 8'd1);
    check("dw.tick", {7'd0, tick_1hz}, 8'd1);
    step();
    check("dw.wrap_off", {7'd0, day_wrap}, 8'd0);
    check("dw.tick_off", {7'd0, tick_1hz}, 8'd0);

    // 4. adjust without carry, then collision with tick carry
    goto(7, 59, 0);
    inc_min = 1'b1;
    step();
    inc_min = 1'b0;
    check_time("adj", 7, 0, 0);
    goto(10, 14, 59);
    run = 1'b1;
    repeat (3) step();
    inc_min = 1'b1;
    step();
    inc_min = 1'b0;
    check_time("coll_min", 10, 15, 0);
    goto(23, 59, 59);
    run = 1'b1;
    repeat (3) step();
    inc_hour = 1'b1;
    step();
    inc_hour = 1'b0;
    check_time("coll_hour", 0, 0, 0);
    check("coll_hour.wrap", {7'd0, day_wrap}, 8'd1);

    // 5. freeze mid-period, resume, then clear mid-period
    goto(1, 2, 3);
    run = 1'b1;
    repeat (2) step();
    run = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("frz.tick", {7'd0, tick_1hz}, 8'd0);
    end
    check_time("frz", 1, 2, 3);
    run = 1'b1;
    step();
    check("resume.tick_early", {7'd0, tick_1hz}, 8'd0);
    step();
    check("resume.tick", {7'd0, tick_1hz}, 8'd1);
    check_time("resume", 1, 2, 4);
    goto(5, 6, 7);
    run = 1'b1;
    repeat (2) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_time("clr", 0, 0, 0);
    check("clr.tick", {7'd0, tick_1hz}, 8'd0);
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("clr.restart%0d", k), {7'd0, tick_1hz}, (k == 4) ? 8'd1 : 8'd0);
    end
    check_time("clr.after", 0, 0, 1);

    // 6. asynchronous reset between edges
    goto(3, 20, 41);
    check_time("pre_rst", 3, 20, 41);
    #2;
    rst_n = 1'b0;
    #1;
    check_time("arst", 0, 0, 0);
    #10;
    rst_n = 1'b1;
    check("range.sec_hi", {6'd0, sec[7:6]}, 8'd0);
    check("range.hour_hi", {5'd0, hour[7:5]}, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
